// File: rtl/gamepad_pmod_receiver_pkg.sv
// Shared constants and types for the Gamepad Pmod receiver.
// Button indices follow the bit order in which each pad shifts out its state.
package gamepad_pkg;

  localparam int BUTTONS_PER_PAD    = 12;
  localparam int DEFAULT_FRAME_BITS = 2 * BUTTONS_PER_PAD;

  localparam int BTN_B      = 11;
  localparam int BTN_Y      = 10;
  localparam int BTN_SELECT = 9;
  localparam int BTN_START  = 8;
  localparam int BTN_UP     = 7;
  localparam int BTN_DOWN   = 6;
  localparam int BTN_LEFT   = 5;
  localparam int BTN_RIGHT  = 4;
  localparam int BTN_A      = 3;
  localparam int BTN_X      = 2;
  localparam int BTN_L      = 1;
  localparam int BTN_R      = 0;

  typedef logic [BUTTONS_PER_PAD-1:0] pad_t;

  // An unplugged pad reads as all ones because of the pull-ups.
  function automatic logic pad_absent(input pad_t field);
    return &field;
  endfunction

endpackage

// File: rtl/gamepad_pmod_receiver_if.sv
// Pin and result bundle between the Pmod header and the receiver.
// The slave side is the receiver; the master side drives pins and reads results.
interface gamepad_pmod_receiver_if;
  import gamepad_pkg::*;

  logic       pmod_data;
  logic       pmod_clk;
  logic       pmod_latch;
  pad_t       buttons0;
  pad_t       buttons1;
  logic [1:0] present;
  logic       frame_valid;
  logic       frame_error;

  modport master (
    output pmod_data, pmod_clk, pmod_latch,
    input  buttons0, buttons1, present, frame_valid, frame_error
  );

  modport slave (
    input  pmod_data, pmod_clk, pmod_latch,
    output buttons0, buttons1, present, frame_valid, frame_error
  );

endinterface

// File: rtl/gamepad_pmod_receiver_sync.sv
// Two-flop synchroniser plus history flop for one asynchronous Pmod pin.
// Both outputs are registered, so a pin edge shows up as rise three cycles later.
module pmod_input_sync (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      meta  <= pin;
      sync  <= meta;
      level <= sync;
      rise  <= sync & ~level;
    end
  end

endmodule

// File: rtl/gamepad_pmod_receiver.sv
// Gamepad Pmod serial receiver: shifts in button bits, commits a frame on latch,
// flags absent pads and clears everything if no good frame arrives in time.
module gamepad_pmod_receiver
  import gamepad_pkg::*;
#(
  parameter int FRAME_BITS     = DEFAULT_FRAME_BITS,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input logic                   clk,
  input logic                   reset,
  gamepad_pmod_receiver_if.slave pmod
);

  localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT_CYCLES);
  localparam logic [4:0]      CNT_MAX  = 5'd31;
  localparam logic [4:0]      CNT_FULL = 5'(FRAME_BITS);

  logic                  data_level, data_rise;
  logic                  clk_level, clk_rise;
  logic                  latch_level, latch_rise;
  logic [FRAME_BITS-1:0] sr;
  logic [4:0]            bit_cnt;
  logic [WD_W-1:0]       wd_cnt;
  pad_t                  field0, field1;
  logic                  commit;
  logic                  unused_sync;

  pmod_input_sync u_sync_data  (.clk(clk), .reset(reset), .pin(pmod.pmod_data),
                                .level(data_level),  .rise(data_rise));
  pmod_input_sync u_sync_clk   (.clk(clk), .reset(reset), .pin(pmod.pmod_clk),
                                .level(clk_level),   .rise(clk_rise));
  pmod_input_sync u_sync_latch (.clk(clk), .reset(reset), .pin(pmod.pmod_latch),
                                .level(latch_level), .rise(latch_rise));

  assign unused_sync = ^{data_rise, clk_level, latch_level};

  assign field0 = sr[2*BUTTONS_PER_PAD-1:BUTTONS_PER_PAD];
  assign field1 = sr[BUTTONS_PER_PAD-1:0];
  assign commit = latch_rise && (bit_cnt == CNT_FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr               <= '0;
      bit_cnt          <= '0;
      wd_cnt           <= '0;
      pmod.buttons0    <= '0;
      pmod.buttons1    <= '0;
      pmod.present     <= '0;
      pmod.frame_valid <= 1'b0;
      pmod.frame_error <= 1'b0;
    end else begin
      pmod.frame_valid <= 1'b0;
      pmod.frame_error <= 1'b0;

      // A latch takes priority over a coincident shift, which is dropped.
      if (latch_rise) begin
        bit_cnt <= '0;
        if (!commit) pmod.frame_error <= 1'b1;
      end else if (clk_rise) begin
        sr <= {sr[FRAME_BITS-2:0], data_level};
        if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 5'd1;
      end

      if (commit) begin
        pmod.frame_valid <= 1'b1;
        pmod.present[0]  <= ~pad_absent(field0);
        pmod.present[1]  <= ~pad_absent(field1);
        pmod.buttons0    <= pad_absent(field0) ? '0 : field0;
        pmod.buttons1    <= pad_absent(field1) ? '0 : field1;
        wd_cnt           <= '0;
      end else if (wd_cnt == WD_MAX) begin
        pmod.buttons0 <= '0;
        pmod.buttons1 <= '0;
        pmod.present  <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_receiver.sv
// Scoreboard bench for gamepad_pmod_receiver: expected frames are queued as
// stimulus is driven and matched against observed strobes.
module tb_gamepad_pmod_receiver;

  typedef struct packed {
    logic        err;
    logic [11:0] b0;
    logic [11:0] b1;
    logic [1:0]  pr;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pd  = 1'b0;
  logic pc  = 1'b0;
  logic pl  = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t_latch = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  obs_cyc[$];

  logic [11:0] m_b0 = '0;
  logic [11:0] m_b1 = '0;
  logic [1:0]  m_pr = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gamepad_pmod_receiver_if bus();
  gamepad_pmod_receiver_if bus_wd();

  assign bus.pmod_data     = pd;
  assign bus.pmod_clk      = pc;
  assign bus.pmod_latch    = pl;
  assign bus_wd.pmod_data  = pd;
  assign bus_wd.pmod_clk   = pc;
  assign bus_wd.pmod_latch = pl;

  gamepad_pmod_receiver #(.FRAME_BITS(24), .TIMEOUT_CYCLES(2_000_000)) dut (
    .clk(clk), .reset(rst), .pmod(bus));

  gamepad_pmod_receiver #(.FRAME_BITS(24), .TIMEOUT_CYCLES(100)) dut_wd (
    .clk(clk), .reset(rst), .pmod(bus_wd));

  always @(negedge clk) begin
    if (bus.frame_valid || bus.frame_error) begin
      obs_q.push_back({bus.frame_error, bus.buttons0, bus.buttons1, bus.present});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      pd = v[i];
      step(3);
      pc = 1'b1;
      step(3);
      pc = 1'b0;
    end
  endtask

  task automatic latch_pulse();
    t_latch = cyc;
    pl = 1'b1;
    step(3);
    pl = 1'b0;
    step(3);
  endtask

  task automatic push_commit(input logic [23:0] f);
    logic [11:0] c0, c1;
    c0 = f[23:12];
    c1 = f[11:0];
    m_pr = {~&c1, ~&c0};
    m_b0 = (&c0) ? 12'h000 : c0;
    m_b1 = (&c1) ? 12'h000 : c1;
    exp_q.push_back({1'b0, m_b0, m_b1, m_pr});
  endtask

  task automatic push_error();
    exp_q.push_back({1'b1, m_b0, m_b1, m_pr});
  endtask

  task automatic fetch(output ev_t o, output int c, output bit got);
    got = 1'b0;
    o = '0;
    c = 0;
    for (int i = 0; i < 20; i++) begin
      if (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        c = obs_cyc.pop_front();
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    n_cmp++;
    if ({bus.buttons0, bus.buttons1, bus.present, bus.frame_valid, bus.frame_error} !== 28'h0) begin
      n_err++;
      $display("FAIL reset_main: got %h want 0",
               {bus.buttons0, bus.buttons1, bus.present, bus.frame_valid, bus.frame_error});
    end
    n_cmp++;
    if ({bus_wd.buttons0, bus_wd.buttons1, bus_wd.present, bus_wd.frame_valid, bus_wd.frame_error} !== 28'h0) begin
      n_err++;
      $display("FAIL reset_wd: got %h want 0",
               {bus_wd.buttons0, bus_wd.buttons1, bus_wd.present, bus_wd.frame_valid, bus_wd.frame_error});
    end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_basic();
    ev_t o, e;
    int c;
    bit got;
    send_bits({40'h0, 12'h801, 12'hFFF}, 24);
    push_commit({12'h801, 12'hFFF});
    e = exp_q.pop_front();
    latch_pulse();
    fetch(o, c, got);
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL basic_strobe: got none want frame_valid");
    end else begin
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL basic_frame: got %h want %h", o, e);
      end
      n_cmp++;
      if (c - t_latch !== 4) begin
        n_err++;
        $display("FAIL basic_latency: got %0d want 4", c - t_latch);
      end
    end
  endtask

  task automatic test_short();
    ev_t o, e;
    int c;
    bit got;
    send_bits(64'hABCDEF, 23);
    push_error();
    e = exp_q.pop_front();
    latch_pulse();
    fetch(o, c, got);
    n_cmp++;
    if (!got || o !== e) begin
      n_err++;
      $display("FAIL short_error: got %h (seen %0d) want %h", o, got, e);
    end
    send_bits({40'h0, 12'h123, 12'h456}, 24);
    push_commit({12'h123, 12'h456});
    e = exp_q.pop_front();
    latch_pulse();
    fetch(o, c, got);
    n_cmp++;
    if (!got || o !== e) begin
      n_err++;
      $display("FAIL short_recover: got %h (seen %0d) want %h", o, got, e);
    end
  endtask

  task automatic test_long();
    ev_t o, e;
    int c;
    bit got;
    int lens[2] = '{30, 56};
    foreach (lens[k]) begin
      send_bits(64'h0, lens[k]);
      push_error();
      e = exp_q.pop_front();
      latch_pulse();
      fetch(o, c, got);
      n_cmp++;
      if (!got || o !== e) begin
        n_err++;
        $display("FAIL long_%0d_error: got %h (seen %0d) want %h", lens[k], o, got, e);
      end
      n_cmp++;
      if ({bus.buttons0, bus.buttons1, bus.present} !== {m_b0, m_b1, m_pr}) begin
        n_err++;
        $display("FAIL long_%0d_held: got %h want %h", lens[k],
                 {bus.buttons0, bus.buttons1, bus.present}, {m_b0, m_b1, m_pr});
      end
    end
  endtask

  task automatic test_simultaneous();
    ev_t o, e;
    int c;
    bit got;
    send_bits({40'h0, 12'hFFF, 12'hA5A}, 24);
    push_commit({12'hFFF, 12'hA5A});
    e = exp_q.pop_front();
    t_latch = cyc;
    pl = 1'b1;
    pc = 1'b1;
    pd = 1'b0;
    step(3);
    pl = 1'b0;
    pc = 1'b0;
    step(3);
    fetch(o, c, got);
    n_cmp++;
    if (!got || o !== e) begin
      n_err++;
      $display("FAIL simul_commit: got %h (seen %0d) want %h", o, got, e);
    end
    send_bits({40'h0, 12'h00F, 12'hF00}, 24);
    push_commit({12'h00F, 12'hF00});
    e = exp_q.pop_front();
    latch_pulse();
    fetch(o, c, got);
    n_cmp++;
    if (!got || o !== e) begin
      n_err++;
      $display("FAIL simul_next: got %h (seen %0d) want %h", o, got, e);
    end
  endtask

  task automatic test_watchdog();
    ev_t o, e;
    int c;
    bit got;
    bit seen;
    send_bits({40'h0, 12'h0F0, 12'hFFF}, 24);
    push_commit({12'h0F0, 12'hFFF});
    e = exp_q.pop_front();
    pl = 1'b1;
    step(3);
    pl = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus_wd.frame_valid) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL wd_commit: got no frame_valid want one");
    end else begin
      step(100);
      n_cmp++;
      if ({bus_wd.buttons0, bus_wd.buttons1, bus_wd.present} !== {12'h0F0, 12'h000, 2'b01}) begin
        n_err++;
        $display("FAIL wd_hold: got %h want %h",
                 {bus_wd.buttons0, bus_wd.buttons1, bus_wd.present}, {12'h0F0, 12'h000, 2'b01});
      end
      step(1);
      n_cmp++;
      if ({bus_wd.buttons0, bus_wd.buttons1, bus_wd.present} !== 26'h0) begin
        n_err++;
        $display("FAIL wd_clear: got %h want 0",
                 {bus_wd.buttons0, bus_wd.buttons1, bus_wd.present});
      end
    end
    fetch(o, c, got);
    n_cmp++;
    if (!got || o !== e) begin
      n_err++;
      $display("FAIL wd_main_frame: got %h (seen %0d) want %h", o, got, e);
    end
    n_cmp++;
    if ({bus.buttons0, bus.present} !== {12'h0F0, 2'b01}) begin
      n_err++;
      $display("FAIL wd_main_hold: got %h want %h", {bus.buttons0, bus.present}, {12'h0F0, 2'b01});
    end
  endtask

  task automatic test_reset_mid_frame();
    ev_t o, e;
    int c;
    bit got;
    send_bits(64'h3FF, 10);
    rst = 1'b1;
    m_b0 = '0;
    m_b1 = '0;
    m_pr = '0;
    step(3);
    n_cmp++;
    if ({bus.buttons0, bus.buttons1, bus.present} !== 26'h0) begin
      n_err++;
      $display("FAIL midreset_clear: got %h want 0", {bus.buttons0, bus.buttons1, bus.present});
    end
    rst = 1'b0;
    step(2);
    send_bits({40'h0, 12'hA0A, 12'h3C3}, 24);
    push_commit({12'hA0A, 12'h3C3});
    e = exp_q.pop_front();
    latch_pulse();
    fetch(o, c, got);
    n_cmp++;
    if (!got || o !== e) begin
      n_err++;
      $display("FAIL midreset_frame: got %h (seen %0d) want %h", o, got, e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short();
    test_long();
    test_simultaneous();
    test_watchdog();
    test_reset_mid_frame();
    step(10);
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL extra_strobes: got %0d unexpected want 0", obs_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
